// File: rtl/dsram_bank.sv
// dsram_bank: data array for one cache way, with byte-granular writes.
// Features: configurable read latency (1 or 2), a selectable read-during-write
// policy, and an optional zero-fill sweep after reset.
//
// Handshake: a request (read and/or write) is taken on any rising edge where
// ready is high and reset is low. There is no backpressure on the read data.
// Each accepted read produces exactly one rd_valid pulse, RD_LATENCY cycles
// later, and results come back in request order. rd holds its last value
// while rd_valid is low.
module dsram_bank #(
  parameter int ADDR_WIDTH    = 13,
  parameter int DATA_WIDTH    = 256,
  parameter int RD_LATENCY    = 1,
  parameter int RDW_MODE      = 0,
  parameter int INIT_ON_RESET = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ADDR_WIDTH-1:0]   a,
  input  logic [DATA_WIDTH/8-1:0] be,
  input  logic [DATA_WIDTH-1:0]   wd,
  input  logic                    write,
  input  logic                    read,
  output logic [DATA_WIDTH-1:0]   rd,
  output logic                    rd_valid,
  output logic                    ready,
  output logic                    init_busy
);

  localparam int ENTRIES  = 2 ** ADDR_WIDTH;
  localparam int BE_WIDTH = DATA_WIDTH / 8;

  // Reject unsupported configurations when the design is elaborated.
  if ((DATA_WIDTH % 8) != 0) begin : g_bad_data_width
    $error("dsram_bank: DATA_WIDTH must be a multiple of 8");
  end
  if ((RD_LATENCY != 1) && (RD_LATENCY != 2)) begin : g_bad_rd_latency
    $error("dsram_bank: RD_LATENCY must be 1 or 2");
  end

  typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_e;

  state_e                  state_q;
  logic [ADDR_WIDTH-1:0]   ptr_q;
  logic [DATA_WIDTH-1:0]   mem [ENTRIES];

  logic                    rd_fire;
  logic                    wr_fire;
  logic [DATA_WIDTH-1:0]   rdata_d;

  logic                    s1_v_q;
  logic [DATA_WIDTH-1:0]   s1_d_q;
  logic [DATA_WIDTH-1:0]   rd_q;
  logic                    rd_valid_q;

  // A request is accepted only in RUN. Reset suppresses acceptance so that
  // a request presented alongside reset has no effect.
  assign ready     = (state_q == ST_RUN);
  assign init_busy = (state_q == ST_INIT);
  assign rd_fire   = read  && ready && !reset;
  assign wr_fire   = write && ready && !reset;

  // Read data as captured at the request edge. Read-first mode returns the
  // stored line. Write-first mode overlays the enabled bytes of a
  // simultaneous write.
  always_comb begin
    rdata_d = mem[a];
    if ((RDW_MODE != 0) && wr_fire) begin
      for (int i = 0; i < BE_WIDTH; i++) begin
        if (be[i]) rdata_d[8*i +: 8] = wd[8*i +: 8];
      end
    end
  end

  // Sweep FSM. INIT zero-fills one entry per cycle. It moves to RUN after
  // the last entry is written.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= (INIT_ON_RESET != 0) ? ST_INIT : ST_RUN;
      ptr_q   <= '0;
    end else if (state_q == ST_INIT) begin
      ptr_q <= ptr_q + 1'b1;
      if (ptr_q == {ADDR_WIDTH{1'b1}}) state_q <= ST_RUN;
    end
  end

  // Array write port. The sweep owns the array during INIT. In RUN, only
  // the enabled bytes are written.
  always_ff @(posedge clk) begin
    if ((state_q == ST_INIT) && !reset) begin
      mem[ptr_q] <= '0;
    end else if (wr_fire) begin
      for (int i = 0; i < BE_WIDTH; i++) begin
        if (be[i]) mem[a][8*i +: 8] <= wd[8*i +: 8];
      end
    end
  end

  // Read pipeline. Reads already in flight drain normally. Reset drops
  // them without emitting rd_valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_v_q     <= 1'b0;
      s1_d_q     <= '0;
      rd_q       <= '0;
      rd_valid_q <= 1'b0;
    end else if (RD_LATENCY == 1) begin
      rd_valid_q <= rd_fire;
      if (rd_fire) rd_q <= rdata_d;
    end else begin
      s1_v_q <= rd_fire;
      if (rd_fire) s1_d_q <= rdata_d;
      rd_valid_q <= s1_v_q;
      if (s1_v_q) rd_q <= s1_d_q;
    end
  end

  assign rd       = rd_q;
  assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_dsram_bank.sv
// Bench for dsram_bank. Two instances share the same stimulus:
//   u_dut0: RD_LATENCY=1, read-first
//   u_dut1: RD_LATENCY=2, write-first
// Each instance has its own expected-data and expected-cycle queues.
module tb_dsram_bank;

  localparam int AW = 4;
  localparam int DW = 256;
  localparam int BW = DW / 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [AW-1:0] a;
  logic [BW-1:0] be;
  logic [DW-1:0] wd;
  logic          write;
  logic          read;

  logic [DW-1:0] rd0, rd1;
  logic          rd_valid0, rd_valid1;
  logic          ready0, ready1;
  logic          busy0, busy1;

  dsram_bank #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(1), .RDW_MODE(0),
               .INIT_ON_RESET(1)) u_dut0 (
    .clk(clk), .reset(reset), .a(a), .be(be), .wd(wd), .write(write),
    .read(read), .rd(rd0), .rd_valid(rd_valid0), .ready(ready0),
    .init_busy(busy0));

  dsram_bank #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(2), .RDW_MODE(1),
               .INIT_ON_RESET(1)) u_dut1 (
    .clk(clk), .reset(reset), .a(a), .be(be), .wd(wd), .write(write),
    .read(read), .rd(rd1), .rd_valid(rd_valid1), .ready(ready1),
    .init_busy(busy1));

  // Clock and cycle counter.
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [DW-1:0] exp0_q[$];
  logic [DW-1:0] exp1_q[$];
  int            t0_q[$];
  int            t1_q[$];

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [DW-1:0] got,
                       input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Drive one cycle of stimulus. When exp_rd is set, the expected data and
  // expected arrival cycle are queued for each instance.
  task automatic drive(input bit r, input bit w, input logic [AW-1:0] ad,
                       input logic [BW-1:0] b, input logic [DW-1:0] d,
                       input bit exp_rd, input logic [DW-1:0] e0,
                       input logic [DW-1:0] e1);
    read  = r;
    write = w;
    a     = ad;
    be    = b;
    wd    = d;
    if (r && exp_rd) begin
      exp0_q.push_back(e0);
      t0_q.push_back(cyc + 1);
      exp1_q.push_back(e1);
      t1_q.push_back(cyc + 2);
    end
    @(posedge clk);
    #1;
    read  = 1'b0;
    write = 1'b0;
  endtask

  task automatic wr(input logic [AW-1:0] ad, input logic [BW-1:0] b,
                    input logic [DW-1:0] d);
    drive(1'b0, 1'b1, ad, b, d, 1'b0, '0, '0);
  endtask

  task automatic rdx(input logic [AW-1:0] ad, input logic [DW-1:0] e0,
                     input logic [DW-1:0] e1);
    drive(1'b1, 1'b0, ad, '0, '0, 1'b1, e0, e1);
  endtask

  logic [DW-1:0] l_a5_3c;
  logic [DW-1:0] l_merge;
  int            n0, n1, k;

  initial begin
    read  = 1'b0;
    write = 1'b0;
    a     = '0;
    be    = '0;
    wd    = '0;
    reset = 1'b1;
    l_a5_3c = {{28{8'hA5}}, {4{8'h3C}}};
    l_merge = {{4{8'h99}}, {28{8'h77}}};

    fork
      // Monitor: compares every rd_valid pulse against the queue head.
      forever begin
        logic [DW-1:0] e;
        int            t;
        @(negedge clk);
        if (rd_valid0) begin
          if (exp0_q.size() == 0) check("dut0_spurious_valid", 1, 0);
          else begin
            e = exp0_q.pop_front();
            t = t0_q.pop_front();
            check("dut0_rd", rd0, e);
            check("dut0_latency", DW'(cyc), DW'(t));
          end
        end
        if (rd_valid1) begin
          if (exp1_q.size() == 0) check("dut1_spurious_valid", 1, 0);
          else begin
            e = exp1_q.pop_front();
            t = t1_q.pop_front();
            check("dut1_rd", rd1, e);
            check("dut1_latency", DW'(cyc), DW'(t));
          end
        end
      end
    join_none

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_rd0", rd0, '0);
    check("rst_rd1", rd1, '0);
    check("rst_valid0", DW'(rd_valid0), 0);
    check("rst_valid1", DW'(rd_valid1), 0);
    check("rst_busy0", DW'(busy0), 1);
    check("rst_ready0", DW'(ready0), 0);
    check("rst_busy1", DW'(busy1), 1);
    check("rst_ready1", DW'(ready1), 0);

    // Start a sweep, then reset again in the middle of it.
    reset = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    check("mid_sweep_busy0", DW'(busy0), 1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Count busy cycles. A request issued during the sweep must be ignored.
    n0 = 0;
    n1 = 0;
    k  = 0;
    while ((busy0 || busy1) && k < 100) begin
      if (k == 2) begin
        write = 1'b1; read = 1'b1; a = 4'd2; be = '1; wd = {32{8'hFF}};
      end else begin
        write = 1'b0; read = 1'b0;
      end
      if (busy0) n0++;
      if (busy1) n1++;
      @(posedge clk);
      #1;
      k++;
    end
    write = 1'b0;
    read  = 1'b0;
    check("init_cycles0", DW'(n0), 16);
    check("init_cycles1", DW'(n1), 16);
    check("ready0_after_init", DW'(ready0), 1);
    check("ready1_after_init", DW'(ready1), 1);

    // Every entry reads as zero, including entry 2.
    for (int i = 0; i < 16; i++) rdx(AW'(i), '0, '0);

    // Byte-enable merge.
    wr(4'd5, '1, {32{8'hA5}});
    wr(4'd5, 32'h0000000F, {32{8'h3C}});
    rdx(4'd5, l_a5_3c, l_a5_3c);

    // Read during write to the same address.
    wr(4'd3, '1, {32{8'h11}});
    drive(1'b1, 1'b1, 4'd3, '1, {32{8'h22}}, 1'b1, {32{8'h11}}, {32{8'h22}});
    rdx(4'd3, {32{8'h22}}, {32{8'h22}});

    // A write with be = 0 changes nothing. A partial read-during-write
    // merges only the enabled bytes.
    wr(4'd7, '1, {32{8'h77}});
    wr(4'd7, '0, {32{8'hEE}});
    rdx(4'd7, {32{8'h77}}, {32{8'h77}});
    drive(1'b1, 1'b1, 4'd7, 32'hF000_0000, {32{8'h99}}, 1'b1, {32{8'h77}},
          l_merge);
    rdx(4'd7, l_merge, l_merge);

    // Back-to-back reads, then rd holds its last value.
    for (int i = 0; i < 4; i++) wr(AW'(i), '1, DW'(i));
    for (int i = 0; i < 4; i++) rdx(AW'(i), DW'(i), DW'(i));
    repeat (4) @(posedge clk);
    #1;
    check("hold_rd0", rd0, DW'(3));
    check("hold_rd1", rd1, DW'(3));
    check("hold_valid0", DW'(rd_valid0), 0);
    check("hold_valid1", DW'(rd_valid1), 0);

    // Reset while a read is in flight. dut0 returns the read on the accept
    // edge. dut1's second stage is flushed.
    read = 1'b1;
    a    = 4'd1;
    exp0_q.push_back(DW'(1));
    t0_q.push_back(cyc + 1);
    @(posedge clk);
    #1;
    read  = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("flush_rd1", rd1, '0);
    check("flush_valid1", DW'(rd_valid1), 0);
    check("flush_rd0", rd0, '0);
    check("flush_busy0", DW'(busy0), 1);
    k = 0;
    while (busy0 && k < 100) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("resweep_cycles", DW'(k), 16);

    // Wait for all expected responses to drain.
    k = 0;
    while ((exp0_q.size() != 0 || exp1_q.size() != 0) && k < 20) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("drain_q0", DW'(exp0_q.size()), 0);
    check("drain_q1", DW'(exp1_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
